// File: rtl/ir_nec_decoder.sv
// NEC infrared remote frame decoder.
// Times falling edges in prescaled ticks; decodes leader, 32 data bits and repeat codes.
module ir_nec_decoder #(
  parameter int TICK_DIV = 120,
  parameter int LEAD_MIN = 1300,
  parameter int LEAD_MAX = 1400,
  parameter int RPT_MIN  = 1080,
  parameter int RPT_MAX  = 1170,
  parameter int ZERO_MIN = 100,
  parameter int ZERO_MAX = 125,
  parameter int ONE_MIN  = 210,
  parameter int ONE_MAX  = 240,
  parameter int TIMEOUT  = 1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        neg_edge,
  output logic [15:0] ir_addr,
  output logic [7:0]  ir_cmd,
  output logic        frame_valid,
  output logic        repeat_valid,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
  localparam logic [10:0] T_LMIN = 11'(LEAD_MIN);
  localparam logic [10:0] T_LMAX = 11'(LEAD_MAX);
  localparam logic [10:0] T_RMIN = 11'(RPT_MIN);
  localparam logic [10:0] T_RMAX = 11'(RPT_MAX);
  localparam logic [10:0] T_ZMIN = 11'(ZERO_MIN);
  localparam logic [10:0] T_ZMAX = 11'(ZERO_MAX);
  localparam logic [10:0] T_OMIN = 11'(ONE_MIN);
  localparam logic [10:0] T_OMAX = 11'(ONE_MAX);
  localparam logic [10:0] T_TO   = 11'(TIMEOUT);

  state_t        state, state_d;
  logic [PW-1:0] presc;
  logic [10:0]   ival;
  logic          tick, tmo;
  logic [31:0]   shreg, shreg_d, sh_shift;
  logic [4:0]    bcnt, bcnt_d;
  logic          have, have_d;
  logic [15:0]   addr_d;
  logic [7:0]    cmd_d;
  logic          fv_d, rv_d, fe_d;
  logic          is_lead, is_rpt, is_zero, is_one, chk_ok;

  assign tick = (presc == PRE_TOP);
  assign tmo  = (ival == T_TO);

  // ival saturates, so an edge after a long gap sees TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      ival  <= '0;
    end else if (neg_edge) begin
      presc <= '0;
      ival  <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick && !tmo)
        ival <= ival + 11'd1;
    end
  end

  assign is_lead = (ival >= T_LMIN) && (ival <= T_LMAX);
  assign is_rpt  = (ival >= T_RMIN) && (ival <= T_RMAX);
  assign is_zero = (ival >= T_ZMIN) && (ival <= T_ZMAX);
  assign is_one  = (ival >= T_OMIN) && (ival <= T_OMAX);

  assign sh_shift = {is_one, shreg[31:1]};
  assign chk_ok   = (sh_shift[31:24] == ~sh_shift[23:16]);

  always_comb begin
    state_d = state;
    shreg_d = shreg;
    bcnt_d  = bcnt;
    have_d  = have;
    addr_d  = ir_addr;
    cmd_d   = ir_cmd;
    fv_d    = 1'b0;
    rv_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (neg_edge)
          state_d = SYNC;
      end
      SYNC: begin
        if (neg_edge) begin
          unique case (1'b1)
            is_lead: begin
              state_d = DATA;
              bcnt_d  = '0;
            end
            is_rpt: begin
              rv_d    = have;
              state_d = IDLE;
            end
            default: ;
          endcase
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (neg_edge) begin
          if (is_zero || is_one) begin
            shreg_d = sh_shift;
            bcnt_d  = bcnt + 5'd1;
            if (bcnt == 5'd31) begin
              state_d = IDLE;
              if (chk_ok) begin
                addr_d = sh_shift[15:0];
                cmd_d  = sh_shift[23:16];
                fv_d   = 1'b1;
                have_d = 1'b1;
              end else begin
                fe_d   = 1'b1;
                have_d = 1'b0;
              end
            end
          end else begin
            fe_d    = 1'b1;
            state_d = SYNC;
          end
        end else if (tmo) begin
          fe_d    = 1'b1;
          have_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shreg        <= '0;
      bcnt         <= '0;
      have         <= 1'b0;
      ir_addr      <= '0;
      ir_cmd       <= '0;
      frame_valid  <= 1'b0;
      repeat_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_d;
      shreg        <= shreg_d;
      bcnt         <= bcnt_d;
      have         <= have_d;
      ir_addr      <= addr_d;
      ir_cmd       <= cmd_d;
      frame_valid  <= fv_d;
      repeat_valid <= rv_d;
      frame_err    <= fe_d;
    end
  end

  assign busy = (state == SYNC) || (state == DATA);

endmodule

// File: doc/ir_nec_decoder.md
Name: ir_nec_decoder

Overview:
- Consumes the single-cycle falling-edge pulses from the IR input edge detector and measures the time between successive falling edges.
- Decodes NEC-format remote frames: leader, 32 data bits LSB-first, and repeat codes.
- Presents a decoded address/command plus valid, repeat and error strobes to the DW8051 peripheral register interface.

Parameters:
- TICK_DIV, 120, clk cycles per timing tick (120 at 12 MHz gives a 10 us tick).
- LEAD_MIN, 1300, minimum leader interval in ticks (13.5 ms nominal).
- LEAD_MAX, 1400, maximum leader interval in ticks.
- RPT_MIN, 1080, minimum repeat interval in ticks (11.25 ms nominal).
- RPT_MAX, 1170, maximum repeat interval in ticks.
- ZERO_MIN, 100, minimum bit-0 interval in ticks (1.125 ms nominal).
- ZERO_MAX, 125, maximum bit-0 interval in ticks.
- ONE_MIN, 210, minimum bit-1 interval in ticks (2.25 ms nominal).
- ONE_MAX, 240, maximum bit-1 interval in ticks.
- TIMEOUT, 1500, tick count without an edge that aborts a frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- neg_edge  input  1  one-cycle pulse per IR-line falling edge (burst start), synchronous to clk.
- ir_addr  output  16  decoded address, {byte1, byte0}; held until the next valid frame.
- ir_cmd  output  8  decoded command byte; held until the next valid frame.
- frame_valid  output  1  one-cycle strobe when a frame with a good command checksum completes.
- repeat_valid  output  1  one-cycle strobe when a repeat code follows a previously valid frame.
- frame_err  output  1  one-cycle strobe on a bad bit interval, timeout mid-data, or checksum fail.
- busy  output  1  high in SYNC and DATA states.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; shift register, bit_cnt, tick prescaler, interval counter and have_frame flag cleared. Reset mid-frame discards the partial frame.
- Prescaler counts 0..TICK_DIV-1 and emits a tick at wrap. It is cleared on every neg_edge.
- Interval counter (11 bits) increments on each tick, saturates at TIMEOUT, and is cleared on every neg_edge. On an edge, the value before clearing is the measured interval.
- IDLE: neg_edge -> SYNC.
- SYNC, on neg_edge:
  - interval in [LEAD_MIN, LEAD_MAX] -> DATA; bit_cnt=0.
  - interval in [RPT_MIN, RPT_MAX] -> repeat_valid=1 if have_frame, else no strobe; then IDLE.
  - any other interval -> stay in SYNC; this edge becomes the new leader candidate. No error strobe.
- SYNC, counter reaches TIMEOUT -> IDLE, no strobe.
- DATA, on neg_edge:
  - interval in [ZERO_MIN, ZERO_MAX] shifts in 0; interval in [ONE_MIN, ONE_MAX] shifts in 1.
  - Shift is right-shift: shreg <= {bit, shreg[31:1]}. bit_cnt increments.
  - Any other interval -> frame_err=1, go to SYNC; this edge becomes the new leader candidate.
- DATA, after the 32nd bit:
  - If shreg[31:24] == ~shreg[23:16]: ir_addr=shreg[15:0], ir_cmd=shreg[23:16], frame_valid=1, have_frame=1.
  - Otherwise: frame_err=1, have_frame=0; ir_addr/ir_cmd unchanged.
  - Either way, go to IDLE.
- DATA, counter reaches TIMEOUT -> frame_err=1, have_frame=0, go to IDLE.
- Latency: every strobe is registered and asserts on the clk edge after the cycle in which the deciding neg_edge was high.
- Strobes are mutually exclusive and last exactly one cycle.
- neg_edge and timeout in the same cycle: the edge wins and the interval is classified using the saturated value.
- Window edges are inclusive. Thresholds are assumed non-overlapping; the block does not check them.

Test Plan:
- TICK_DIV=4; edges at NEC intervals for addr 0x00/0xFF, cmd 0x45/0xBA, ending with the stop burst edge -> one frame_valid pulse, ir_addr=16'hFF00, ir_cmd=8'h45, busy low afterwards.
- Same frame, then one edge after 1120 ticks, then a second edge 1110 ticks after that -> exactly one repeat_valid pulse. A repeat interval after reset with no prior frame -> no strobe.
- Frame with cmd byte 0x45, inverse byte 0xBB -> frame_err pulse; ir_cmd keeps its previous value; a following repeat gives no repeat_valid.
- Edges stop after 10 data bits -> frame_err exactly TIMEOUT ticks after the last edge, state IDLE.
- Bit interval of 160 ticks at bit 5, followed immediately by a valid full frame -> frame_err once, then frame_valid for the new frame.
- rst asserted for 3 cycles at bit 20 -> outputs 0 asynchronously; a subsequent full frame decodes correctly.
